// File: rtl/exclusive_max_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exclusive_max_unit
//  Brief    : Race-logic exclusive-max gate. It emits one PULSE_WIDTH pulse at
//             the later of two input events, and only when the events fall in
//             distinct cycles of the gamma window.
//             Optional macro FALLING_EDGE_EN: inputs idle high and the event
//             is a 1->0 transition.
//  Revision : 1.0  initial release
// ============================================================================
module exclusive_max_unit #(
   parameter int PULSE_WIDTH       = 8,
   parameter int GAMMA_CYCLE_WIDTH = 16
) (
   input  logic aclk,
   input  logic grst_n,
   input  logic rst,
   input  logic a,
   input  logic b,
   output logic q
);

`ifdef FALLING_EDGE_EN
   localparam logic c_idle = 1'b1;
`else
   localparam logic c_idle = 1'b0;
`endif
   localparam logic c_act = ~c_idle;

   localparam int c_idx_w = $clog2(GAMMA_CYCLE_WIDTH + 1);
   localparam int c_cnt_w = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam logic [c_idx_w-1:0] c_idx_max  = c_idx_w'(GAMMA_CYCLE_WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(PULSE_WIDTH - 1);

   logic [c_idx_w-1:0] r_idx;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_a_d;
   logic               r_b_d;
   logic               r_a_seen;
   logic               r_b_seen;
   logic               r_tie;
   logic               r_done;
   logic               r_q;

   logic w_in_win;
   logic w_ev_a;
   logic w_ev_b;
   logic w_tie;
   logic w_fire;

   // The index saturates at the window size, so this also masks late events.
   assign w_in_win = (r_idx < c_idx_max);
   assign w_ev_a   = w_in_win && (a == c_act) && (r_a_d == c_idle) && !r_a_seen;
   assign w_ev_b   = w_in_win && (b == c_act) && (r_b_d == c_idle) && !r_b_seen;
   assign w_tie    = w_ev_a && w_ev_b && !r_a_seen && !r_b_seen;
   assign w_fire   = ((w_ev_a && r_b_seen) || (w_ev_b && r_a_seen)) && !r_tie && !r_done;

   assign q = r_q;

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         r_idx    <= '0;
         r_cnt    <= '0;
         r_a_d    <= c_idle;
         r_b_d    <= c_idle;
         r_a_seen <= 1'b0;
         r_b_seen <= 1'b0;
         r_tie    <= 1'b0;
         r_done   <= 1'b0;
         r_q      <= 1'b0;
      end else if (rst) begin
         r_idx    <= '0;
         r_cnt    <= '0;
         r_a_d    <= c_idle;
         r_b_d    <= c_idle;
         r_a_seen <= 1'b0;
         r_b_seen <= 1'b0;
         r_tie    <= 1'b0;
         r_done   <= 1'b0;
         r_q      <= 1'b0;
      end else begin
         if (r_idx != c_idx_max) begin
            r_idx <= r_idx + c_idx_w'(1);
         end
         r_a_d <= a;
         r_b_d <= b;
         if (w_ev_a) begin
            r_a_seen <= 1'b1;
         end
         if (w_ev_b) begin
            r_b_seen <= 1'b1;
         end
         if (w_tie) begin
            r_tie <= 1'b1;
         end
         // The fire edge counts as the first pulse cycle; the counter covers the rest.
         if (w_fire) begin
            r_q    <= 1'b1;
            r_cnt  <= c_cnt_load;
            r_done <= 1'b1;
         end else if (r_q) begin
            if (r_cnt == '0) begin
               r_q <= 1'b0;
            end else begin
               r_cnt <= r_cnt - c_cnt_w'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exclusive_max_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exclusive_max_unit
//  Brief    : Scoreboard bench for exclusive_max_unit; stimulus queues the
//             expected q per cycle and a monitor compares it after each edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exclusive_max_unit;

`ifdef FALLING_EDGE_EN
   localparam logic c_idle = 1'b1;
`else
   localparam logic c_idle = 1'b0;
`endif
   localparam logic c_act = ~c_idle;

   logic aclk;
   logic grst_n;
   logic rst;
   logic a;
   logic b;
   logic q;

   typedef struct {
      logic qe;
      int   tst;
      int   idx;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   exclusive_max_unit #(
      .PULSE_WIDTH      (8),
      .GAMMA_CYCLE_WIDTH(16)
   ) dut (
      .aclk  (aclk),
      .grst_n(grst_n),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .q     (q)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Monitor: each edge that has a queued expectation is checked 2 time units later.
   initial begin
      exp_t e;
      forever begin
         @(posedge aclk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (q !== e.qe) begin
               n_fail++;
               $display("FAIL q test%0d idx%0d: got %b expected %b", e.tst, e.idx, q, e.qe);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic av, input logic bv, input logic rv,
                       input logic qe, input int tst, input int idx);
      @(negedge aclk);
      a   = av ? c_act : c_idle;
      b   = bv ? c_act : c_idle;
      rst = rv;
      sb.push_back(exp_t'{qe, tst, idx});
   endtask

   // One rst edge, then n indices driven from bit masks (bit i = active at index i).
   task automatic run_gamma(input int tst, input logic [31:0] am, input logic [31:0] bm,
                            input logic [31:0] qm, input int n);
      step(1'b0, 1'b0, 1'b1, 1'b0, tst, -1);
      for (int i = 0; i < n; i++) begin
         step(am[i], bm[i], 1'b0, qm[i], tst, i);
      end
   endtask

   initial begin
      int guard;
      grst_n = 1'b0;
      rst    = 1'b0;
      a      = c_idle;
      b      = c_idle;
      #12;
      n_tests++;
      if (q !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_q: got %b expected 0", q);
      end
      @(negedge aclk);
      grst_n = 1'b1;

      // No events at all
      run_gamma(1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 16);
      // a at 2, b at 4, both held 8 cycles: pulse on indices 4..11
      run_gamma(2, 32'h0000_03FC, 32'h0000_0FF0, 32'h0000_0FF0, 20);
      // b first, a later: same pulse
      run_gamma(3, 32'h0000_0FF0, 32'h0000_03FC, 32'h0000_0FF0, 20);
      // Tie at 2, a toggles again at 6: no pulse
      run_gamma(4, 32'h0000_00CC, 32'h0000_03FC, 32'h0000_0000, 16);
      // b at index 16 falls outside the window
      run_gamma(5, 32'h0000_03FC, 32'h0007_0000, 32'h0000_0000, 20);
      // rst at index 6 mid-pulse (next run_gamma's rst step expects q=0)
      run_gamma(6, 32'h0000_03FC, 32'h0000_0FF0, 32'h0000_0030, 6);
      // Fresh cycle after the rst behaves normally
      run_gamma(7, 32'h0000_03FC, 32'h0000_0FF0, 32'h0000_0FF0, 20);
      // PULSE_WIDTH boundary: b at 0, a at 15 (last index): pulse 15..22
      run_gamma(8, 32'h0000_8000, 32'h0000_0001, 32'h007F_8000, 24);

      // grst_n asserted mid-pulse drops q without a clock edge
      run_gamma(9, 32'h0000_03FC, 32'h0000_0FF0, 32'h0000_0070, 7);
      @(posedge aclk);
      #3;
      grst_n = 1'b0;
      #1;
      n_tests++;
      if (q !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_q: got %b expected 0", q);
      end
      @(negedge aclk);
      a      = c_idle;
      b      = c_idle;
      grst_n = 1'b1;

      run_gamma(10, 32'h0000_03FC, 32'h0000_0FF0, 32'h0000_0FF0, 20);

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge aclk);
         guard++;
      end
      #4;
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exclusive_max_unit.md
Name: exclusive_max_unit

Overview:
- Temporal-coded (race-logic) exclusive-max gate used in the gamma-cycle neuron/column datapath.
- Each input carries one event per gamma cycle: its first active transition.
- q emits one output pulse at the time of the later input event, but only if both inputs fired in different cycles.
- A tie (same-cycle events) or a missing input produces no output for that gamma cycle.

Parameters:
- PULSE_WIDTH, 8, length in aclk cycles of the output pulse on q (>=1).
- GAMMA_CYCLE_WIDTH, 16, number of aclk cycles in one gamma cycle. Input events at cycle index >= GAMMA_CYCLE_WIDTH are ignored.

Ports:
- aclk  input  1  system clock; all state updates on rising edge.
- grst_n  input  1  global reset, asynchronous, active-low.
- rst  input  1  gamma-cycle clear, synchronous, active-high; starts a new gamma cycle.
- a  input  1  temporal input A; event = first active transition in the gamma cycle.
- b  input  1  temporal input B; event = first active transition in the gamma cycle.
- q  output  1  registered output pulse, active-high.

Behaviour:
- grst_n low (async), or rst high at a clock edge, does all of the following:
  - clears a_seen, b_seen, tie, done, q and the pulse counter;
  - sets the cycle index to 0;
  - loads the prev-sample registers a_d/b_d with the idle level (0, or 1 under FALLING_EDGE_EN).
- Cycle index: the first aclk edge with grst_n high and rst low is index 0. The index increments per edge and saturates at GAMMA_CYCLE_WIDTH.
- Event detection at an edge with index < GAMMA_CYCLE_WIDTH:
  - ev_a = a at active level while a_d at idle level and !a_seen; ev_b likewise.
  - a_d/b_d sample a/b every edge.
- Only the first event per input per gamma cycle counts. Later toggles, including pulse falling edges, are ignored.
- Fire condition, evaluated at the same edge the event is sampled:
  - ev_a with b_seen, or ev_b with a_seen, and !tie and !done.
  - Result: q<=1, counter<=PULSE_WIDTH-1, done<=1.
  - Latency: q is high immediately after the edge that samples the later event.
- Tie: ev_a and ev_b at the same edge while neither was previously seen sets tie=1. q stays 0 for the rest of the gamma cycle.
- Single event only, or no events: q stays 0.
- Pulse: q remains high for exactly PULSE_WIDTH edges, then returns to 0. At most one pulse per gamma cycle.
- rst or grst_n asserted mid-pulse: q drops to 0 (synchronously for rst, immediately for grst_n).
- Inputs are assumed synchronous to aclk; no synchronizers are included.
- Reset value of q: 0.

Optional Feature:
- Macro FALLING_EDGE_EN.
- Defined: idle input level is 1 and the event is a 1->0 transition; a_d/b_d reset to 1.
- Undefined: idle level 0 and the event is a 0->1 transition.
- q polarity, pulse length and tie rules are identical in both modes.

Test Plan:
- No events: a=b=0 for a full 16-cycle gamma cycle -> q=0 throughout.
- a rises at index 2, b rises at index 4, each held 8 cycles -> q=1 for indices 4..11 (8 cycles), 0 otherwise. The falling edges of a/b have no effect.
- b rises at index 2, a rises at index 4 -> same as above: q=1 for indices 4..11.
- a and b rise together at index 2 -> q=0 for the whole gamma cycle. A second toggle of a at index 6 still gives q=0.
- Event after window / reset:
  - a at 2, b at index 16 -> q=0.
  - rst pulsed at index 6 during an active pulse -> q=0 from the next edge; new gamma cycle behaves as fresh.
  - grst_n low mid-pulse -> q=0 asynchronously.
- FALLING_EDGE_EN defined: a,b idle 1; a falls at 2, b falls at 4 -> q=1 for indices 4..11. Simultaneous falls -> q=0.
